// File: rtl/rf_fifo.sv
// ----------------------------------------------------------------------------
// rf_fifo
//   Synchronous register-file FIFO with registered read data.
//   A word is pushed into a depth x ws register array at the write pointer.
//   The oldest word is popped into DataOut on the edge that samples the pop,
//   and valid is high for the one cycle that follows that edge.
//   Rejected pushes and pops raise a one-cycle overflow or underflow pulse.
//
// Parameters
//   ws     data word width in bits
//   depth  number of storage words; must be a power of two, at least 2
//   as     pointer width, $clog2(depth)
//
// Ports
//   clk        master clock; all state changes on its rising edge
//   reset      synchronous, active-high reset
//   push       write request; DataIn is stored this cycle when accepted
//   pop        read request; oldest word is in DataOut next cycle
//   DataIn     write data
//   DataOut    registered read data; holds when no pop is accepted
//   valid      DataOut was loaded by a pop accepted on the previous edge
//   full       count == depth
//   empty      count == 0
//   count      number of stored words, 0..depth
//   overflow   one-cycle pulse: push rejected
//   underflow  one-cycle pulse: pop rejected
// ----------------------------------------------------------------------------
module rf_fifo #(
   parameter int ws    = 4,
   parameter int depth = 8,
   parameter int as    = $clog2(depth)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic          pop,
   input  logic [ws-1:0] DataIn,
   output logic [ws-1:0] DataOut,
   output logic          valid,
   output logic          full,
   output logic          empty,
   output logic [as:0]   count,
   output logic          overflow,
   output logic          underflow
);

   localparam logic [as:0]   FULL_CNT = (as+1)'(depth);
   localparam logic [as:0]   CNT_ONE  = (as+1)'(1);
   localparam logic [as-1:0] PTR_ONE  = as'(1);

   logic [ws-1:0] mem_q [depth];

   logic [as-1:0] wr_ptr_q, wr_ptr_d;
   logic [as-1:0] rd_ptr_q, rd_ptr_d;
   logic [as:0]   count_q,  count_d;
   logic [ws-1:0] dout_q,   dout_d;
   logic          valid_q,  valid_d;
   logic          ovf_q,    ovf_d;
   logic          udf_q,    udf_d;

   logic          full_w;
   logic          empty_w;
   logic          pop_acc;
   logic          push_acc;

   assign full_w  = (count_q == FULL_CNT);
   assign empty_w = (count_q == '0);

   // A pop is never accepted from an empty FIFO, so a simultaneous push
   // into an empty FIFO cannot write through to DataOut. When full, the
   // accepted pop frees the slot the push is about to fill.
   assign pop_acc  = pop  & ~empty_w;
   assign push_acc = push & (~full_w | pop_acc);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      dout_d   = dout_q;
      valid_d  = 1'b0;
      ovf_d    = push & ~push_acc;
      udf_d    = pop  & ~pop_acc;

      // Pointer width equals log2(depth), so plain increment wraps modulo depth.
      if (push_acc) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end

      if (pop_acc) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
         dout_d   = mem_q[rd_ptr_q];
         valid_d  = 1'b1;
      end

      case ({push_acc, pop_acc})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         dout_q   <= '0;
         valid_q  <= 1'b0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         dout_q   <= dout_d;
         valid_q  <= valid_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

   // Storage is not reset; only the pointers and count define its contents.
   // When full with push and pop together, wr_ptr == rd_ptr: the read above
   // sees the old word because the write lands on the same edge.
   always_ff @(posedge clk) begin
      if (!reset && push_acc) begin
         mem_q[wr_ptr_q] <= DataIn;
      end
   end

   assign DataOut   = dout_q;
   assign valid     = valid_q;
   assign full      = full_w;
   assign empty     = empty_w;
   assign count     = count_q;
   assign overflow  = ovf_q;
   assign underflow = udf_q;

endmodule

// File: tb/tb_rf_fifo.sv
// ----------------------------------------------------------------------------
// tb_rf_fifo
//   Directed bench for rf_fifo (ws=4, depth=8). The stimulus tasks push the
//   expected read data into a queue; an independent negedge monitor pops
//   and compares whenever the DUT raises valid. Flags and count are checked
//   one step after each edge against the bench's own occupancy tracking
//   and against hand-computed constants at the interesting points.
// ----------------------------------------------------------------------------
module tb_rf_fifo;

   localparam int WS    = 4;
   localparam int DEPTH = 8;
   localparam int AS    = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic          push;
   logic          pop;
   logic [WS-1:0] DataIn;
   logic [WS-1:0] DataOut;
   logic          valid;
   logic          full;
   logic          empty;
   logic [AS:0]   count;
   logic          overflow;
   logic          underflow;

   int errors = 0;
   int checks = 0;

   logic [WS-1:0] exp_q[$];     // words the DUT must present, in order
   logic [WS-1:0] stored_q[$];  // words the bench believes are stored

   rf_fifo #(.ws(WS), .depth(DEPTH), .as(AS)) dut (
      .clk      (clk),
      .reset    (reset),
      .push     (push),
      .pop      (pop),
      .DataIn   (DataIn),
      .DataOut  (DataOut),
      .valid    (valid),
      .full     (full),
      .empty    (empty),
      .count    (count),
      .overflow (overflow),
      .underflow(underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Data monitor: runs independently of the stimulus.
   always @(negedge clk) begin
      if (valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid: got DataOut=%0d with nothing expected at %0t",
                     DataOut, $time);
         end else begin
            chk("dout_order", int'(DataOut), int'(exp_q.pop_front()));
         end
      end
   end

   // One clock cycle of stimulus; checks status one step after the edge.
   task automatic op(input logic ph, input logic pp, input logic [WS-1:0] d);
      bit pa, ha, ovf, udf;
      pa  = pp && (stored_q.size() > 0);
      ha  = ph && ((stored_q.size() < DEPTH) || pa);
      ovf = ph && !ha;
      udf = pp && !pa;
      push   = ph;
      pop    = pp;
      DataIn = d;
      if (pa) exp_q.push_back(stored_q.pop_front());
      if (ha) stored_q.push_back(d);
      @(posedge clk);
      #1;
      chk("valid",     int'(valid),     int'(pa));
      chk("overflow",  int'(overflow),  int'(ovf));
      chk("underflow", int'(underflow), int'(udf));
      chk("count",     int'(count),     stored_q.size());
      chk("full",      int'(full),      int'(stored_q.size() == DEPTH));
      chk("empty",     int'(empty),     int'(stored_q.size() == 0));
      push = 1'b0;
      pop  = 1'b0;
   endtask

   // Reset for n cycles with push and pop held high; everything must stay clear.
   task automatic do_reset(input int n);
      reset  = 1'b1;
      push   = 1'b1;
      pop    = 1'b1;
      DataIn = 4'h3;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         if (i == 0) begin
            chk("drained_before_reset", exp_q.size(), 0);
            exp_q.delete();
            stored_q.delete();
         end
         #1;
         chk("rst_count",   int'(count),     0);
         chk("rst_empty",   int'(empty),     1);
         chk("rst_full",    int'(full),      0);
         chk("rst_dout",    int'(DataOut),   0);
         chk("rst_valid",   int'(valid),     0);
         chk("rst_ovf",     int'(overflow),  0);
         chk("rst_udf",     int'(underflow), 0);
      end
      reset = 1'b0;
      push  = 1'b0;
      pop   = 1'b0;
   endtask

   initial begin
      reset  = 1'b1;
      push   = 1'b1;
      pop    = 1'b1;
      DataIn = '0;
      #1;

      // Reset held two cycles with push and pop active.
      do_reset(2);
      op(1'b0, 1'b0, 4'h0);
      chk("post_rst_count", int'(count), 0);
      chk("post_rst_valid", int'(valid), 0);

      // Two pushes, two pops.
      op(1'b1, 1'b0, 4'hA);
      op(1'b1, 1'b0, 4'h5);
      chk("two_count", int'(count), 2);
      op(1'b0, 1'b1, 4'h0);
      chk("first_pop_dout",  int'(DataOut), 4'hA);
      chk("first_pop_valid", int'(valid),   1);
      op(1'b0, 1'b1, 4'h0);
      chk("second_pop_dout", int'(DataOut), 4'h5);
      op(1'b0, 1'b0, 4'h0);
      chk("hold_dout",  int'(DataOut), 4'h5);
      chk("hold_valid", int'(valid),   0);
      chk("back_empty", int'(empty),   1);

      // Fill to full, overflow, drain in order.
      for (int i = 0; i < 8; i++) op(1'b1, 1'b0, 4'(i));
      chk("full_flag",  int'(full),  1);
      chk("full_count", int'(count), 8);
      op(1'b1, 1'b0, 4'hF);
      chk("ovf_pulse",  int'(overflow), 1);
      chk("ovf_count",  int'(count),    8);
      op(1'b0, 1'b0, 4'h0);
      chk("ovf_one_cycle", int'(overflow), 0);
      for (int i = 0; i < 8; i++) op(1'b0, 1'b1, 4'h0);
      chk("drain_last", int'(DataOut), 7);
      chk("drain_empty", int'(empty), 1);

      // Simultaneous push and pop at full.
      for (int i = 0; i < 8; i++) op(1'b1, 1'b0, 4'(i + 3));
      op(1'b1, 1'b1, 4'h9);
      chk("pp_full_count", int'(count),    8);
      chk("pp_full_ovf",   int'(overflow), 0);
      chk("pp_full_dout",  int'(DataOut),  3);
      for (int i = 0; i < 8; i++) op(1'b0, 1'b1, 4'h0);
      chk("pp_full_last", int'(DataOut), 4'h9);

      // Underflow cases.
      op(1'b0, 1'b1, 4'h0);
      chk("udf_pop_pulse", int'(underflow), 1);
      chk("udf_pop_valid", int'(valid),     0);
      chk("udf_pop_dout",  int'(DataOut),   4'h9);
      op(1'b1, 1'b1, 4'hC);
      chk("udf_pp_pulse", int'(underflow), 1);
      chk("udf_pp_valid", int'(valid),     0);
      chk("udf_pp_count", int'(count),     1);
      chk("udf_pp_dout",  int'(DataOut),   4'h9);
      op(1'b0, 1'b1, 4'h0);
      chk("udf_pp_word", int'(DataOut), 4'hC);

      // Interleaved stream wrapping the pointers, then reset mid-stream.
      op(1'b1, 1'b0, 4'h1);
      op(1'b1, 1'b0, 4'h2);
      for (int i = 0; i < 20; i++) begin
         op(1'b1, 1'b0, 4'((i * 7 + 5) % 16));
         op(1'b0, 1'b1, 4'h0);
      end
      chk("stream_count", int'(count), 2);
      op(1'b1, 1'b0, 4'hE);
      op(1'b0, 1'b1, 4'h0);
      do_reset(1);
      op(1'b0, 1'b0, 4'h0);
      chk("mid_rst_count", int'(count), 0);
      chk("mid_rst_empty", int'(empty), 1);
      chk("mid_rst_valid", int'(valid), 0);
      op(1'b0, 1'b1, 4'h0);
      chk("mid_rst_udf", int'(underflow), 1);

      repeat (2) @(posedge clk);
      #1;
      chk("final_drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
